// File: rtl/ifc_driver.sv
// ifc_driver: command-driven stepper that walks an (X, Y, Q) interface
// toward a combinational responder, accumulating the returned Z values.
//
// Ports:
//   clk, rst            sole clock; asynchronous active-high reset
//   cmd_valid/ready     command handshake (ready only in IDLE, outside reset)
//   cmd_x0, cmd_y0      initial X / Y values
//   cmd_step            Q value held for the run; also the per-step X increment
//   cmd_count           number of steps (0 -> straight to DONE, empty result)
//   ifc_x, ifc_y, ifc_q interface fields presented to the responder
//   ifc_z               responder result, combinational from ifc_x/y/q
//   res_valid/ready     result handshake (valid while in DONE)
//   res_sum             wrapping sum of the sampled Z values
//   res_xor             XOR of the sampled Z values
//   busy                high in RUN and DONE
module ifc_driver #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [15:0]      cmd_x0,
    input  logic [15:0]      cmd_y0,
    input  logic [7:0]       cmd_step,
    input  logic [CNT_W-1:0] cmd_count,
    output logic [15:0]      ifc_x,
    output logic [15:0]      ifc_y,
    output logic [7:0]       ifc_q,
    input  logic [15:0]      ifc_z,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_sum,
    output logic [15:0]      res_xor,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_n;
    logic [15:0]        x_n;
    logic [15:0]        y_n;
    logic [7:0]         q_n;
    logic [ACC_W-1:0]   sum_n;
    logic [15:0]        xor_n;

    // Status decodes of the state register; ready is also gated by reset
    assign cmd_ready = (state == IDLE) && !rst;
    assign busy      = (state != IDLE);
    assign res_valid = (state == DONE);

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            ifc_x   <= '0;
            ifc_y   <= '0;
            ifc_q   <= '0;
            res_sum <= '0;
            res_xor <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            ifc_x   <= x_n;
            ifc_y   <= y_n;
            ifc_q   <= q_n;
            res_sum <= sum_n;
            res_xor <= xor_n;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        x_n     = ifc_x;
        y_n     = ifc_y;
        q_n     = ifc_q;
        sum_n   = res_sum;
        xor_n   = res_xor;

        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    x_n     = cmd_x0;
                    y_n     = cmd_y0;
                    q_n     = cmd_step;
                    cnt_n   = cmd_count;
                    sum_n   = '0;
                    xor_n   = '0;
                    state_n = (cmd_count == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // Z reflects the current X/Y/Q; sample it, then advance the walk
                sum_n = res_sum + ACC_W'(ifc_z);
                xor_n = res_xor ^ ifc_z;
                x_n   = ifc_x + 16'(ifc_q);
                y_n   = ifc_y - 16'd1;
                cnt_n = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ifc_driver.sv
// Directed self-checking bench for ifc_driver: a 24-bit accumulator instance
// with a selectable responder (X+Y or X) and a 16-bit instance with a
// constant 0xFFFF responder for the wrap case.
module tb_ifc_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    // Instance A: ACC_W = 24
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [15:0] cmd_x0 = '0;
    logic [15:0] cmd_y0 = '0;
    logic [7:0]  cmd_step = '0;
    logic [7:0]  cmd_count = '0;
    logic [15:0] ifc_x, ifc_y, ifc_z;
    logic [7:0]  ifc_q;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [23:0] res_sum;
    logic [15:0] res_xor;
    logic        busy;
    logic        mode_x = 1'b0;   // 0: Z = X+Y, 1: Z = X

    // Instance B: ACC_W = 16
    logic        b_valid = 1'b0;
    logic        b_ready;
    logic [7:0]  b_count = '0;
    logic [15:0] b_x, b_y;
    logic [7:0]  b_q;
    logic        b_res_valid;
    logic        b_res_ready = 1'b0;
    logic [15:0] b_sum;
    logic [15:0] b_xor;
    logic        b_busy;

    int n_cmp = 0;
    int n_bad = 0;
    int n;
    int seen;

    always #5 clk = ~clk;

    assign ifc_z = mode_x ? ifc_x : (ifc_x + ifc_y);

    ifc_driver #(.CNT_W(8), .ACC_W(24)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_step(cmd_step), .cmd_count(cmd_count),
        .ifc_x(ifc_x), .ifc_y(ifc_y), .ifc_q(ifc_q), .ifc_z(ifc_z),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_xor(res_xor), .busy(busy)
    );

    ifc_driver #(.CNT_W(8), .ACC_W(16)) dut16 (
        .clk(clk), .rst(rst),
        .cmd_valid(b_valid), .cmd_ready(b_ready),
        .cmd_x0(16'd0), .cmd_y0(16'd0), .cmd_step(8'd1), .cmd_count(b_count),
        .ifc_x(b_x), .ifc_y(b_y), .ifc_q(b_q), .ifc_z(16'hFFFF),
        .res_valid(b_res_valid), .res_ready(b_res_ready),
        .res_sum(b_sum), .res_xor(b_xor), .busy(b_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".ready"}, 32'(cmd_ready), 32'd0);
        check({tag, ".valid"}, 32'(res_valid), 32'd0);
        check({tag, ".busy"},  32'(busy), 32'd0);
        check({tag, ".x"},     32'(ifc_x), 32'd0);
        check({tag, ".y"},     32'(ifc_y), 32'd0);
        check({tag, ".q"},     32'(ifc_q), 32'd0);
        check({tag, ".sum"},   32'(res_sum), 32'd0);
        check({tag, ".xor"},   32'(res_xor), 32'd0);
    endtask

    task automatic send(input logic [15:0] x0, input logic [15:0] y0,
                        input logic [7:0] st, input logic [7:0] cnt);
        cmd_x0 = x0; cmd_y0 = y0; cmd_step = st; cmd_count = cnt;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    initial begin
        // Reset state, before any clock edge
        #1 rst = 1'b1;
        #2;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_reset.ready", 32'(cmd_ready), 32'd1);

        // X0=17 Y0=21 STEP=1 COUNT=3, Z = X+Y
        @(negedge clk);
        send(16'd17, 16'd21, 8'd1, 8'd3);
        check("t1.x_c1", 32'(ifc_x), 32'd17);
        check("t1.y_c1", 32'(ifc_y), 32'd21);
        check("t1.busy", 32'(busy), 32'd1);
        check("t1.ready_busy", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        check("t1.x_c2", 32'(ifc_x), 32'd18);
        check("t1.y_c2", 32'(ifc_y), 32'd20);
        check("t1.q_c2", 32'(ifc_q), 32'd1);
        @(negedge clk);
        check("t1.x_c3", 32'(ifc_x), 32'd19);
        check("t1.y_c3", 32'(ifc_y), 32'd19);
        check("t1.valid_c3", 32'(res_valid), 32'd0);
        @(negedge clk);
        check("t1.valid_c4", 32'(res_valid), 32'd1);
        check("t1.sum", 32'(res_sum), 32'd114);
        check("t1.xor", 32'(res_xor), 32'd38);

        // Hold result 5 cycles with a competing command pending
        cmd_x0 = 16'd999; cmd_y0 = 16'd7; cmd_count = 8'd4; cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold.valid", 32'(res_valid), 32'd1);
            check("hold.sum", 32'(res_sum), 32'd114);
            check("hold.xor", 32'(res_xor), 32'd38);
            check("hold.ready", 32'(cmd_ready), 32'd0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        cmd_valid = 1'b0;
        check("hs.valid", 32'(res_valid), 32'd0);
        check("hs.ready", 32'(cmd_ready), 32'd1);
        check("hs.no_accept_x", 32'(ifc_x), 32'd20);
        check("hs.busy", 32'(busy), 32'd0);

        // Z = X; X wraps past 0xFFFF, Y wraps below 0
        mode_x = 1'b1;
        send(16'hFFFF, 16'h0000, 8'd2, 8'd2);
        check("t2.x_c1", 32'(ifc_x), 32'hFFFF);
        @(negedge clk);
        check("t2.x_c2", 32'(ifc_x), 32'h0001);
        check("t2.y_c2", 32'(ifc_y), 32'hFFFF);
        @(negedge clk);
        check("t2.valid", 32'(res_valid), 32'd1);
        check("t2.sum", 32'(res_sum), 32'h10000);
        check("t2.xor", 32'(res_xor), 32'hFFFE);
        check("t2.y_end", 32'(ifc_y), 32'hFFFE);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        mode_x = 1'b0;

        // COUNT = 0 goes straight to DONE with an empty result
        send(16'd5, 16'd9, 8'd3, 8'd0);
        check("t3.valid", 32'(res_valid), 32'd1);
        check("t3.sum", 32'(res_sum), 32'd0);
        check("t3.xor", 32'(res_xor), 32'd0);
        check("t3.x", 32'(ifc_x), 32'd5);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;

        // Unaligned reset pulse during the 2nd RUN cycle of COUNT=10
        send(16'd1, 16'd2, 8'd3, 8'd10);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_all_zero("abort");
        #1 rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (res_valid) seen++;
        end
        check("abort.no_result", 32'(seen), 32'd0);
        check("abort.ready", 32'(cmd_ready), 32'd1);

        // Fresh command after abort: Z = 7 then 8
        send(16'd3, 16'd4, 8'd2, 8'd2);
        n = 1;
        while (!res_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t4.latency", 32'(n), 32'd3);
        check("t4.sum", 32'(res_sum), 32'd15);
        check("t4.xor", 32'(res_xor), 32'd15);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;

        // 16-bit accumulator wrap over 255 steps of Z = 0xFFFF
        b_count = 8'd255;
        b_valid = 1'b1;
        @(negedge clk);
        b_valid = 1'b0;
        n = 1;
        while (!b_res_valid && n < 400) begin
            @(negedge clk);
            check("t5.q_const", 32'(b_q), 32'd1);
            n++;
        end
        check("t5.latency", 32'(n), 32'd256);
        check("t5.sum", 32'(b_sum), 32'hFF01);
        check("t5.xor", 32'(b_xor), 32'hFFFF);
        b_res_ready = 1'b1;
        @(negedge clk);
        b_res_ready = 1'b0;
        check("t5.ready_after", 32'(b_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
